uart_rx_par_chk: RTL and testbench

Parametrised receive-side parity checker for the UART RX path, the successor to the fixed 8-bit even/odd checker. It captures DATA_WIDTH serial bits LSB-first from the oversampled bit sampler and checks an optional parity bit in one of four modes. It presents the assembled word with a one-cycle valid strobe and keeps a saturating parity-error count for status readback. It sits between the bit sampler/edge counter and the RX FSM/deserializer consumer.

---
 rtl/uart_rx_par_chk.sv | 158 +++++++++++++++
 tb/tb_uart_rx_par_chk.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_par_chk.sv
// Receive-side parity checker: assembles DATA_WIDTH bits LSB-first on each sample
// strobe, checks an optional parity bit (even/odd/mark/space), and counts parity errors.
module uart_rx_par_chk #(
  parameter int DATA_WIDTH  = 8,
  parameter int SAMPLE_EDGE = 7,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  par_chk_en,
  input  logic                  sampled_bit,
  input  logic [5:0]            edge_cnt,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int BC_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  run_par_q, run_par_d;
  logic                  par_en_q, par_en_d;
  logic [1:0]            par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic                  stb;
  logic                  frame_done;
  logic                  err_inc;
  logic [DATA_WIDTH-1:0] shreg_nxt;

  function automatic logic exp_parity(input logic [1:0] typ, input logic rp);
    case (typ)
      2'b00:   return rp;
      2'b01:   return ~rp;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign stb       = par_chk_en && (edge_cnt == 6'(SAMPLE_EDGE));
  assign shreg_nxt = shreg_q | (DATA_WIDTH'(sampled_bit) << bit_cnt_q);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    run_par_d    = run_par_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    frame_done   = 1'b0;

    if (!par_chk_en) begin
      // Dropping the enable abandons whatever was in flight; data_out keeps the last word.
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      shreg_d   = '0;
      par_err_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          bit_cnt_d = '0;
          shreg_d   = '0;
          run_par_d = 1'b0;
          par_err_d = 1'b0;
        end
        S_DATA: begin
          if (stb) begin
            shreg_d   = shreg_nxt;
            run_par_d = run_par_q ^ sampled_bit;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BC_W'(DATA_WIDTH - 1)) begin
              if (par_en_q) begin
                state_d = S_PAR;
              end else begin
                state_d    = S_HOLD;
                frame_done = 1'b1;
                data_out_d = shreg_nxt;
              end
            end
          end
        end
        S_PAR: begin
          if (stb) begin
            par_err_d  = (sampled_bit != exp_parity(par_typ_q, run_par_q));
            frame_done = 1'b1;
            data_out_d = shreg_q;
            state_d    = S_HOLD;
          end
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end

    data_valid_d = frame_done;
  end

  // A clear coinciding with a new error leaves the count at one so the error is kept.
  always_comb begin
    err_inc   = frame_done && par_err_d;
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = ERR_CNT_W'(err_inc);
    end else if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      run_par_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 2'b00;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      run_par_q    <= run_par_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_par_chk.sv
// Bench for uart_rx_par_chk: two instances (8-bit with 2-bit error counter, 7-bit with
// 8-bit counter) driven by directed and random frames against a word-level model.
module tb_uart_rx_par_chk;

  logic       CLK;
  logic       RST;
  logic       en  [2];
  logic       sb  [2];
  logic [5:0] ec  [2];
  logic       pe  [2];
  logic [1:0] pt  [2];
  logic       clr [2];

  logic [7:0] dout_a;
  logic       vld_a, perr_a;
  logic [1:0] cnt_a;
  logic [6:0] dout_b;
  logic       vld_b, perr_b;
  logic [7:0] cnt_b;

  int checks = 0;
  int errors = 0;
  int mcnt  [2];
  int mdout [2];

  uart_rx_par_chk #(.DATA_WIDTH(8), .SAMPLE_EDGE(7), .ERR_CNT_W(2)) u_a (
    .CLK(CLK), .RST(RST), .par_chk_en(en[0]), .sampled_bit(sb[0]), .edge_cnt(ec[0]),
    .PAR_EN(pe[0]), .PAR_TYP(pt[0]), .err_clr(clr[0]),
    .data_out(dout_a), .data_valid(vld_a), .par_err(perr_a), .err_cnt(cnt_a));

  uart_rx_par_chk #(.DATA_WIDTH(7), .SAMPLE_EDGE(7), .ERR_CNT_W(8)) u_b (
    .CLK(CLK), .RST(RST), .par_chk_en(en[1]), .sampled_bit(sb[1]), .edge_cnt(ec[1]),
    .PAR_EN(pe[1]), .PAR_TYP(pt[1]), .err_clr(clr[1]),
    .data_out(dout_b), .data_valid(vld_b), .par_err(perr_b), .err_cnt(cnt_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int width_of(input int s);
    return (s == 0) ? 8 : 7;
  endfunction

  function automatic int cnt_max(input int s);
    return (s == 0) ? 3 : 255;
  endfunction

  function automatic logic [31:0] g_dout(input int s);
    return (s == 0) ? 32'(dout_a) : 32'(dout_b);
  endfunction
  function automatic logic [31:0] g_vld(input int s);
    return (s == 0) ? 32'(vld_a) : 32'(vld_b);
  endfunction
  function automatic logic [31:0] g_perr(input int s);
    return (s == 0) ? 32'(perr_a) : 32'(perr_b);
  endfunction
  function automatic logic [31:0] g_cnt(input int s);
    return (s == 0) ? 32'(cnt_a) : 32'(cnt_b);
  endfunction

  // Expected parity bit from the population count of the received word.
  function automatic logic exp_par(input int data, input logic [1:0] typ);
    int ones;
    ones = $countones(data);
    case (typ)
      2'b00:   return logic'(ones % 2);
      2'b01:   return logic'(1 - (ones % 2));
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bit_slot(input int s, input logic b, input logic c);
    sb[s] = b;
    for (int k = 0; k < 2; k++) begin
      ec[s] = 6'($urandom_range(8, 40));
      tick();
    end
    ec[s]  = 6'd7;
    clr[s] = c;
    tick();
    ec[s]  = 6'($urandom_range(8, 40));
    clr[s] = 1'b0;
  endtask

  task automatic frame(input int s, input int data, input bit pen, input logic [1:0] typ,
                       input logic [1:0] typ_after, input logic pbit, input bit clr_fin);
    int   dw;
    int   expd;
    logic experr;
    logic [8:0] dv;
    dw     = width_of(s);
    expd   = data & ((1 << dw) - 1);
    dv     = 9'(data);
    experr = pen && (pbit != exp_par(expd, typ));
    pe[s]  = pen;
    pt[s]  = typ;
    en[s]  = 1'b1;
    ec[s]  = 6'($urandom_range(8, 40));
    tick();
    pt[s]  = typ_after;
    pe[s]  = 1'($urandom_range(0, 1));
    for (int i = 0; i < dw; i++) begin
      bit_slot(s, dv[i], (i == dw - 1) && !pen && clr_fin);
    end
    if (pen) begin
      chk("valid_before_parity", g_vld(s), 0);
      bit_slot(s, pbit, clr_fin);
    end
    if (clr_fin) mcnt[s] = experr ? 1 : 0;
    else if (experr && mcnt[s] < cnt_max(s)) mcnt[s]++;
    mdout[s] = expd;
    chk("valid_pulse", g_vld(s), 1);
    chk("data_out", g_dout(s), 32'(expd));
    chk("par_err", g_perr(s), 32'(experr));
    chk("err_cnt", g_cnt(s), 32'(mcnt[s]));
    tick();
    chk("valid_single", g_vld(s), 0);
    bit_slot(s, 1'($urandom_range(0, 1)), 1'b0);
    chk("hold_ignores_stb_vld", g_vld(s), 0);
    chk("hold_data_out", g_dout(s), 32'(expd));
    chk("hold_par_err", g_perr(s), 32'(experr));
    en[s] = 1'b0;
    tick();
    chk("par_err_clear_on_idle", g_perr(s), 0);
    chk("idle_data_out", g_dout(s), 32'(mdout[s]));
  endtask

  initial begin
    int d;
    int sat_tab [5];
    sat_tab = '{1, 2, 3, 3, 3};
    RST = 1'b0;
    for (int s = 0; s < 2; s++) begin
      en[s] = 1'b0; sb[s] = 1'b0; ec[s] = 6'd0; pe[s] = 1'b0; pt[s] = 2'b00; clr[s] = 1'b0;
      mcnt[s] = 0; mdout[s] = 0;
    end
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_data_out", g_dout(s), 0);
      chk("rst_valid", g_vld(s), 0);
      chk("rst_par_err", g_perr(s), 0);
      chk("rst_err_cnt", g_cnt(s), 0);
    end
    RST = 1'b1;
    tick();

    frame(0, 'hA5, 1, 2'b00, 2'b00, 1'b0, 0);
    frame(0, 'h3C, 1, 2'b01, 2'b01, 1'b0, 0);
    chk("odd_err_cnt_after", g_cnt(0), 1);
    frame(1, 'h55, 0, 2'b00, 2'b00, 1'b0, 0);

    frame(0, 'h81, 1, 2'b10, 2'b10, 1'b0, 0);
    frame(0, 'h81, 1, 2'b11, 2'b11, 1'b0, 0);
    frame(0, 'h81, 1, 2'b10, 2'b11, 1'b0, 0);
    chk("mark_latched_cnt", g_cnt(0), 3);

    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    mcnt[0] = 0;
    chk("err_clr", g_cnt(0), 0);
    for (int k = 0; k < 5; k++) begin
      d = int'($urandom_range(0, 255));
      frame(0, d, 1, 2'b00, 2'b00, ~exp_par(d, 2'b00), 0);
      chk("sat_sequence", g_cnt(0), 32'(sat_tab[k]));
    end
    frame(0, 'h5A, 1, 2'b01, 2'b01, ~exp_par('h5A, 2'b01), 1);
    chk("clr_with_error", g_cnt(0), 1);

    en[0] = 1'b1; pe[0] = 1'b1; pt[0] = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) begin
      bit_slot(0, 1'b1, 1'b0);
      chk("abort_no_valid", g_vld(0), 0);
    end
    en[0] = 1'b0;
    tick();
    chk("abort_valid", g_vld(0), 0);
    chk("abort_data_out", g_dout(0), 32'(mdout[0]));
    chk("abort_err_cnt", g_cnt(0), 32'(mcnt[0]));
    chk("abort_par_err", g_perr(0), 0);
    frame(0, 'h12, 1, 2'b00, 2'b00, 1'b0, 0);

    for (int r = 0; r < 24; r++) begin
      frame(r % 2, int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    frame(0, 'hC3, 1, 2'b00, 2'b00, 1'b1, 0);
    en[0] = 1'b1; pe[0] = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) bit_slot(0, 1'b1, 1'b0);
    #3;
    RST = 1'b0;
    #1;
    chk("async_rst_data_out", g_dout(0), 0);
    chk("async_rst_valid", g_vld(0), 0);
    chk("async_rst_par_err", g_perr(0), 0);
    chk("async_rst_err_cnt", g_cnt(0), 0);
    chk("async_rst_data_out_b", g_dout(1), 0);
    mcnt[0] = 0; mcnt[1] = 0; mdout[0] = 0; mdout[1] = 0;
    en[0] = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    frame(0, 'h6E, 1, 2'b01, 2'b01, 1'b1, 0);
    frame(1, 'h2B, 1, 2'b00, 2'b00, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
